id_issue_buffer: RTL and testbench

- Parametrised decode-to-issue buffer between the decoder and the issue stage.
- Generalises the single-register decode/issue handoff into a DEPTH-entry FIFO with a per-entry control-flow flag.
- Adds an optional limit on how many control-flow entries may be buffered at once.
- Adds occupancy and control-flow count outputs for the issue stage and performance counters.

---
 rtl/id_issue_buffer.sv | 117 +++++++++++
 tb/tb_id_issue_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_buffer.sv
// Decode-to-issue FIFO: DEPTH entries, each with a control-flow flag, plus an
// optional cap on how many control-flow entries may be buffered at once.
module id_issue_buffer #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 64,
  parameter int CF_LIMIT   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic [DATA_WIDTH-1:0]    decoded_entry_i,
  input  logic                     decoded_is_cf_i,
  input  logic                     decoded_valid_i,
  output logic                     decoded_ready_o,
  output logic [DATA_WIDTH-1:0]    issue_entry_o,
  output logic                     issue_is_cf_o,
  output logic                     issue_valid_o,
  input  logic                     issue_ack_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic [$clog2(DEPTH):0]   cf_count_o
);

  localparam int          PW     = $clog2(DEPTH);
  localparam int          CW     = PW + 1;
  localparam int unsigned CF_LIM = CF_LIMIT;

  typedef enum logic [1:0] {
    UPD_NONE = 2'b00,
    UPD_POP  = 2'b01,
    UPD_PUSH = 2'b10,
    UPD_BOTH = 2'b11
  } upd_e;

  logic [DATA_WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0]      cf_q;
  logic [DEPTH-1:0]      valid_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         usage;
  logic [CW-1:0]         cf_count;

  logic full;
  logic cf_blocked;
  logic issue_valid;
  logic push;
  logic pop;
  logic cf_in;
  logic cf_out;
  upd_e upd;

  always_comb begin
    full        = (usage == CW'(DEPTH));
    cf_blocked  = (CF_LIM != 0) && decoded_is_cf_i && (32'(cf_count) >= CF_LIM);
    issue_valid = (usage != '0) && valid_q[rd_ptr];
    // Ready is held low in reset so the decoder cannot hand off into a dead buffer.
    decoded_ready_o = rst_ni && !flush_i && !full && !cf_blocked;
    push   = decoded_valid_i && decoded_ready_o;
    pop    = issue_ack_i && issue_valid && !flush_i;
    cf_in  = push && decoded_is_cf_i;
    cf_out = pop && cf_q[rd_ptr];
    upd    = upd_e'({push, pop});
  end

  always_comb begin
    issue_valid_o = issue_valid;
    issue_entry_o = issue_valid ? entry_q[rd_ptr] : '0;
    issue_is_cf_o = issue_valid ? cf_q[rd_ptr] : 1'b0;
    usage_o       = usage;
    cf_count_o    = cf_count;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usage    <= '0;
      cf_count <= '0;
      valid_q  <= '0;
      cf_q     <= '0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      usage    <= '0;
      cf_count <= '0;
      valid_q  <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        valid_q[wr_ptr] <= 1'b1;
        cf_q[wr_ptr]    <= decoded_is_cf_i;
      end
      case (upd)
        UPD_PUSH: usage <= usage + CW'(1);
        UPD_POP:  usage <= usage - CW'(1);
        default:  usage <= usage;
      endcase
      // A control-flow push and pop in the same cycle cancel out.
      case ({cf_in, cf_out})
        2'b10:   cf_count <= cf_count + CW'(1);
        2'b01:   cf_count <= cf_count - CW'(1);
        default: cf_count <= cf_count;
      endcase
    end
  end

  // Payload storage has no reset; the valid bits alone gate the outputs.
  always_ff @(posedge clk_i) begin
    if (push) begin
      entry_q[wr_ptr] <= decoded_entry_i;
    end
  end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Bench for id_issue_buffer: a CF-limited DEPTH=2 instance and an unlimited
// DEPTH=4 instance share one stimulus stream and are checked against a queue model.
module tb_id_issue_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [63:0] dd;
  logic        dcf;
  logic        dv;
  logic        ack;

  logic        rdy_a, vld_a, cf_a;
  logic [63:0] ent_a;
  logic [1:0]  usage_a, cfc_a;
  logic        rdy_b, vld_b, cf_b;
  logic [63:0] ent_b;
  logic [2:0]  usage_b, cfc_b;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  id_issue_buffer #(.DEPTH(2), .DATA_WIDTH(64), .CF_LIMIT(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .decoded_entry_i(dd), .decoded_is_cf_i(dcf), .decoded_valid_i(dv),
    .decoded_ready_o(rdy_a), .issue_entry_o(ent_a), .issue_is_cf_o(cf_a),
    .issue_valid_o(vld_a), .issue_ack_i(ack), .usage_o(usage_a), .cf_count_o(cfc_a)
  );

  id_issue_buffer #(.DEPTH(4), .DATA_WIDTH(64), .CF_LIMIT(0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .decoded_entry_i(dd), .decoded_is_cf_i(dcf), .decoded_valid_i(dv),
    .decoded_ready_o(rdy_b), .issue_entry_o(ent_b), .issue_is_cf_o(cf_b),
    .issue_valid_o(vld_b), .issue_ack_i(ack), .usage_o(usage_b), .cf_count_o(cfc_b)
  );

  // Reference model: one queue of buffered entries per instance.
  typedef struct packed {
    logic [63:0] d;
    logic        cf;
  } ent_t;

  ent_t mq [2][$];

  bit          p_valid [2];
  logic [63:0] p_entry [2];
  logic        p_cf    [2];
  logic        p_ack;
  logic        p_flush;

  typedef struct {
    logic        v;
    logic        cf;
    logic [63:0] d;
    logic        ack;
    logic        fl;
    logic        e_ready;
    logic        e_valid;
    logic [63:0] e_entry;
    logic        e_cf;
    int          e_usage;
    int          e_cfc;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  function automatic vec_t mk(logic v, logic cf, logic [63:0] d, logic a, logic fl,
                              logic er, logic ev, logic [63:0] ee, logic ec, int eu, int ecf);
    vec_t r;
    r.v = v; r.cf = cf; r.d = d; r.ack = a; r.fl = fl;
    r.e_ready = er; r.e_valid = ev; r.e_entry = ee; r.e_cf = ec;
    r.e_usage = eu; r.e_cfc = ecf;
    return r;
  endfunction

  function automatic int m_depth(int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int m_limit(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int m_cf_count(int k);
    int n = 0;
    for (int i = 0; i < mq[k].size(); i++) if (mq[k][i].cf) n++;
    return n;
  endfunction

  function automatic logic m_ready(int k);
    return rst_n && !flush && (mq[k].size() < m_depth(k)) &&
           !(dcf && m_limit(k) != 0 && m_cf_count(k) >= m_limit(k));
  endfunction

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || flush) begin
        mq[k].delete();
      end else begin
        bit   pu;
        bit   po;
        ent_t e;
        pu = dv && m_ready(k);
        po = ack && (mq[k].size() > 0);
        e.d = dd;
        e.cf = dcf;
        if (po) void'(mq[k].pop_front());
        if (pu) mq[k].push_back(e);
      end
    end
  endtask

  task automatic check_dut(int k, logic rdy, logic vld, logic [63:0] ent, logic cf,
                           int usage, int cfc);
    bit          e_vld;
    logic [63:0] e_ent;
    logic        e_cf;
    e_vld = mq[k].size() > 0;
    e_ent = e_vld ? mq[k][0].d : 64'h0;
    e_cf  = e_vld ? mq[k][0].cf : 1'b0;
    check_val($sformatf("dut%0d_ready", k), rdy, m_ready(k));
    check_val($sformatf("dut%0d_valid", k), vld, e_vld);
    check_val($sformatf("dut%0d_entry", k), ent, e_ent);
    check_val($sformatf("dut%0d_is_cf", k), cf, e_cf);
    check_val($sformatf("dut%0d_usage", k), 64'(usage), 64'(mq[k].size()));
    check_val($sformatf("dut%0d_cf_count", k), 64'(cfc), 64'(m_cf_count(k)));
    check_val($sformatf("dut%0d_inv_usage_le_depth", k), (usage <= m_depth(k)), 1'b1);
    check_val($sformatf("dut%0d_inv_cf_le_usage", k), (cfc <= usage), 1'b1);
    if (m_limit(k) != 0)
      check_val($sformatf("dut%0d_inv_cf_le_limit", k), (cfc <= m_limit(k)), 1'b1);
    if (p_valid[k] && !p_ack && !p_flush) begin
      check_val($sformatf("dut%0d_stable_entry", k), ent, p_entry[k]);
      check_val($sformatf("dut%0d_stable_cf", k), cf, p_cf[k]);
    end
    p_valid[k] = vld;
    p_entry[k] = ent;
    p_cf[k]    = cf;
  endtask

  task automatic sample();
    @(negedge clk);
    check_dut(0, rdy_a, vld_a, ent_a, cf_a, int'(usage_a), int'(cfc_a));
    check_dut(1, rdy_b, vld_b, ent_b, cf_b, int'(usage_b), int'(cfc_b));
    p_ack   = ack;
    p_flush = flush;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(logic v, logic cf, logic [63:0] d, logic a, logic fl);
    dv = v; dcf = cf; dd = d; ack = a; flush = fl;
  endtask

  task automatic applyStimulus(vec_t t);
    drive(t.v, t.cf, t.d, t.ack, t.fl);
  endtask

  task automatic checkOutput(int i, vec_t t);
    check_val($sformatf("vec%0d_ready", i), rdy_a, t.e_ready);
    check_val($sformatf("vec%0d_valid", i), vld_a, t.e_valid);
    check_val($sformatf("vec%0d_entry", i), ent_a, t.e_entry);
    check_val($sformatf("vec%0d_is_cf", i), cf_a, t.e_cf);
    check_val($sformatf("vec%0d_usage", i), 64'(usage_a), 64'(t.e_usage));
    check_val($sformatf("vec%0d_cf_count", i), 64'(cfc_a), 64'(t.e_cfc));
  endtask

  task automatic check_reset_state(string tag);
    check_val({tag, "_a_valid"}, vld_a, 1'b0);
    check_val({tag, "_a_entry"}, ent_a, 64'h0);
    check_val({tag, "_a_is_cf"}, cf_a, 1'b0);
    check_val({tag, "_a_usage"}, 64'(usage_a), 64'h0);
    check_val({tag, "_a_cf_count"}, 64'(cfc_a), 64'h0);
    check_val({tag, "_a_ready"}, rdy_a, 1'b0);
    check_val({tag, "_b_valid"}, vld_b, 1'b0);
    check_val({tag, "_b_usage"}, 64'(usage_b), 64'h0);
    check_val({tag, "_b_cf_count"}, 64'(cfc_b), 64'h0);
    check_val({tag, "_b_ready"}, rdy_b, 1'b0);
  endtask

  initial begin
    int ack_pct;

    // Rows: inputs {v, cf, data, ack, flush}, then DEPTH=2/CF_LIMIT=1 outputs
    // {ready, valid, entry, is_cf, usage, cf_count} seen before that cycle's edge.
    vec[0]  = mk(1, 0, 64'h6f, 0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[1]  = mk(0, 0, 64'h0,  1, 0,  1, 1, 64'h6f, 0, 1, 0);
    vec[2]  = mk(0, 0, 64'h0,  0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[3]  = mk(1, 0, 64'hA,  0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[4]  = mk(1, 0, 64'hB,  0, 0,  1, 1, 64'hA,  0, 1, 0);
    vec[5]  = mk(1, 0, 64'hC,  1, 0,  0, 1, 64'hA,  0, 2, 0);
    vec[6]  = mk(1, 0, 64'hC,  0, 0,  1, 1, 64'hB,  0, 1, 0);
    vec[7]  = mk(0, 0, 64'h0,  1, 0,  0, 1, 64'hB,  0, 2, 0);
    vec[8]  = mk(0, 0, 64'h0,  1, 0,  1, 1, 64'hC,  0, 1, 0);
    vec[9]  = mk(1, 1, 64'hb3, 0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[10] = mk(1, 1, 64'h11, 0, 0,  0, 1, 64'hb3, 1, 1, 1);
    vec[11] = mk(1, 0, 64'h22, 0, 0,  1, 1, 64'hb3, 1, 1, 1);
    vec[12] = mk(1, 1, 64'h11, 1, 0,  0, 1, 64'hb3, 1, 2, 1);
    vec[13] = mk(1, 1, 64'h11, 0, 0,  1, 1, 64'h22, 0, 1, 0);
    vec[14] = mk(0, 0, 64'h0,  1, 0,  0, 1, 64'h22, 0, 2, 1);
    vec[15] = mk(0, 0, 64'h0,  1, 0,  1, 1, 64'h11, 1, 1, 1);
    vec[16] = mk(1, 0, 64'h31, 0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[17] = mk(1, 1, 64'h32, 0, 0,  1, 1, 64'h31, 0, 1, 0);
    vec[18] = mk(1, 0, 64'h33, 1, 1,  0, 1, 64'h31, 0, 2, 1);
    vec[19] = mk(1, 0, 64'h34, 0, 0,  1, 0, 64'h0,  0, 0, 0);
    vec[20] = mk(0, 0, 64'h0,  0, 0,  1, 1, 64'h34, 0, 1, 0);
    vec[21] = mk(0, 0, 64'h0,  1, 0,  1, 1, 64'h34, 0, 1, 0);

    rst_n = 1'b0;
    drive(0, 0, 64'h0, 0, 0);
    p_valid[0] = 0; p_valid[1] = 0; p_ack = 0; p_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vec[i]);
      sample();
      checkOutput(i, vec[i]);
      advance();
    end

    // Streaming push+pop at usage 1 across pointer wrap.
    drive(1, 0, 64'h40, 0, 0);
    sample();
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 64'h41 + 64'(i), 1, 0);
      sample();
      check_val("stream_usage", 64'(usage_a), 64'h1);
      check_val("stream_entry", ent_a, 64'h40 + 64'(i));
      advance();
    end
    drive(0, 0, 64'h0, 1, 0);
    sample();
    advance();

    // Two cf entries: the unlimited instance keeps both, the limited one refuses the second.
    drive(1, 1, 64'h51, 0, 0);
    sample();
    advance();
    drive(1, 1, 64'h52, 0, 0);
    sample();
    check_val("cflim_ready_a", rdy_a, 1'b0);
    check_val("cf0_ready_b", rdy_b, 1'b1);
    advance();
    drive(1, 0, 64'h53, 0, 0);
    sample();
    check_val("cf0_count_b", 64'(cfc_b), 64'h2);
    check_val("cflim_count_a", 64'(cfc_a), 64'h1);
    advance();
    drive(0, 0, 64'h0, 0, 0);
    sample();
    check_val("pre_reset_usage_a", 64'(usage_a), 64'h2);
    advance();

    // Reset dropped between edges must clear outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset");
    mq[0].delete();
    mq[1].delete();
    p_valid[0] = 0; p_valid[1] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(vec[i]);
      sample();
      checkOutput(100 + i, vec[i]);
      advance();
    end

    for (int n = 0; n < 1500; n++) begin
      case ((n / 250) % 3)
        0:       ack_pct = 25;
        1:       ack_pct = 55;
        default: ack_pct = 85;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, {$urandom, $urandom},
            $urandom_range(0, 99) < ack_pct, $urandom_range(0, 39) == 0);
      sample();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
